dat_tx_serializer: RTL

Single-line SD write-data transmitter in the `sd_clk` domain. Drains 32-bit words from the TX buffer's read port (`tx_buf_rd_dat`/`tx_buf_dout`/`tx_buf_empty`) and serializes one block onto DAT0 as follows:
- start bit, data MSB-first, CRC16, end bit;
- then receives the card's CRC status token and, optionally, busy.

It sits directly downstream of the dual-clock TX buffer and upstream of the DAT pad.

---
 rtl/dat_tx_serializer_pkg.sv | 48 ++++
 rtl/dat_crc16.sv | 34 +++
 rtl/dat_tx_serializer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dat_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// dat_tx_serializer_pkg
// Shared definitions for the SD single-line write-data transmitter:
//   - DTX_FIFO_WIDTH : TX buffer word width
//   - dtx_state_t    : FSM state encodings (DTX_*)
//   - dtx_err_t      : status codes reported on err_code
//   - DTX_CRC_TOKEN  : positive CRC status token returned by the card
//   - crc16_step     : one serial step of CRC16-CCITT (poly 0x1021)
// Optional feature macro: DAT_TX_BUSY_WAIT_EN adds the DTX_BUSY state.
// -----------------------------------------------------------------------------
package dat_tx_serializer_pkg;

  localparam int DTX_FIFO_WIDTH = 32;

  typedef enum logic [3:0] {
    DTX_IDLE      = 4'd0,
    DTX_FETCH     = 4'd1,
    DTX_LOAD      = 4'd2,
    DTX_START     = 4'd3,
    DTX_DATA      = 4'd4,
    DTX_CRC       = 4'd5,
    DTX_END       = 4'd6,
    DTX_NCRC      = 4'd7,
    DTX_STAT_WAIT = 4'd8,
    DTX_STAT      = 4'd9,
`ifdef DAT_TX_BUSY_WAIT_EN
    DTX_BUSY      = 4'd10,
`endif
    DTX_DONE      = 4'd11
  } dtx_state_t;

  typedef enum logic [1:0] {
    DTX_OK       = 2'b00,
    DTX_CRC_NEG  = 2'b01,
    DTX_TIMEOUT  = 2'b10,
    DTX_UNDERRUN = 2'b11
  } dtx_err_t;

  localparam logic [2:0] DTX_CRC_TOKEN = 3'b010;

  // One bit of CRC16-CCITT, message bit entering at the top.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

endpackage

// File: rtl/dat_crc16.sv
// -----------------------------------------------------------------------------
// dat_crc16
// Serial CRC16-CCITT (poly 0x1021, init 0x0000), one bit per enabled cycle.
// Shared by the TX and RX DAT paths.
// Ports:
//   clk     : clock, rising edge
//   rst_L   : asynchronous active-low reset (crc -> 0)
//   clr     : synchronous clear, wins over en
//   en      : fold bit_in into the CRC this cycle
//   bit_in  : serial message bit
//   crc     : current CRC remainder
// -----------------------------------------------------------------------------
module dat_crc16
  import dat_tx_serializer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_L,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      crc <= 16'h0000;
    end else if (clr) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/dat_tx_serializer.sv
// -----------------------------------------------------------------------------
// dat_tx_serializer
// Single-line SD write-data transmitter (sd_clk domain). Pulls 32-bit words
// from the TX buffer and sends one block on DAT0: start bit, data MSB-first,
// CRC16, end bit; then collects the card's CRC status token and, when
// DAT_TX_BUSY_WAIT_EN is defined, waits for the card to release busy.
// Ports:
//   sd_clk, rst_L   : clock (rising edge), async active-low reset
//   start, blk_size : one-cycle block request and its byte length
//   tx_buf_dout     : buffer data, valid the cycle after tx_buf_rd_dat
//   tx_buf_empty    : buffer has no word available
//   tx_buf_rd_dat   : one-cycle read strobe per word
//   dat_in          : DAT0 from the pad (status token / busy)
//   dat_out, dat_oe : DAT0 value and output enable
//   busy, done      : transfer in progress / one-cycle completion pulse
//   err_code        : 00 ok, 01 CRC status negative, 10 timeout, 11 underrun
//   dbg_state       : current FSM state
// Configuration macro: DAT_TX_BUSY_WAIT_EN
// -----------------------------------------------------------------------------
module dat_tx_serializer
  import dat_tx_serializer_pkg::*;
#(
  parameter int FIFO_WIDTH   = DTX_FIFO_WIDTH,
  parameter int BLK_W        = 12,
  parameter int STAT_TIMEOUT = 64
) (
  input  logic                  sd_clk,
  input  logic                  rst_L,
  input  logic                  start,
  input  logic [BLK_W-1:0]      blk_size,
  input  logic [FIFO_WIDTH-1:0] tx_buf_dout,
  input  logic                  tx_buf_empty,
  output logic                  tx_buf_rd_dat,
  input  logic                  dat_in,
  output logic                  dat_out,
  output logic                  dat_oe,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic [3:0]            dbg_state
);

  localparam int WORDS_W = BLK_W - 2;
  localparam int CNT_MAX = (FIFO_WIDTH > STAT_TIMEOUT) ? FIFO_WIDTH : STAT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

`ifdef DAT_TX_BUSY_WAIT_EN
  localparam dtx_state_t STAT_NEXT = DTX_BUSY;
`else
  localparam dtx_state_t STAT_NEXT = DTX_DONE;
`endif

  dtx_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [WORDS_W-1:0]    words_q;       // words left, including the one shifting
  logic [FIFO_WIDTH-1:0] shreg_q;
  logic [FIFO_WIDTH-1:0] hold_q;
  logic [FIFO_WIDTH-1:0] hold_nxt;
  logic                  fetch_pend_q;  // a DATA-phase read is returning this cycle
  logic                  underrun_q;
  logic [2:0]            tok_q;
  dtx_err_t              err_q;
  logic [15:0]           crc_val;
  logic                  crc_clr;
  logic                  crc_en;
  logic                  last_bit;
  logic                  refill_pt;
  logic                  more_words;
  logic                  underrun_det;
  logic [3:0]            crc_idx;

  assign last_bit     = (cnt_q == CNT_W'(FIFO_WIDTH - 1));
  assign refill_pt    = (state_q == DTX_DATA) && (cnt_q == CNT_W'(FIFO_WIDTH - 2));
  assign more_words   = (words_q > WORDS_W'(1));
  assign underrun_det = refill_pt && more_words && tx_buf_empty;
  // The refill word arrives on the last bit of the current word, so the
  // word-boundary load bypasses the hold register in that cycle.
  assign hold_nxt     = fetch_pend_q ? tx_buf_dout : hold_q;
  assign crc_idx      = 4'd15 - cnt_q[3:0];
  assign err_code     = err_q;
  assign dbg_state    = state_q;

  dat_crc16 u_crc (
    .clk    (sd_clk),
    .rst_L  (rst_L),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (shreg_q[FIFO_WIDTH-1]),
    .crc    (crc_val)
  );

  always_ff @(posedge sd_clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= DTX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer handshake: a word is taken only in a cycle where tx_buf_rd_dat=1,
  // which is raised only while tx_buf_empty=0; the word is on tx_buf_dout the
  // following cycle. start is accepted only in IDLE and dropped otherwise.
  always_comb begin
    state_d       = state_q;
    tx_buf_rd_dat = 1'b0;
    dat_out       = 1'b1;
    dat_oe        = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;
    case (state_q)
      DTX_IDLE: begin
        busy = 1'b0;
        if (start) state_d = DTX_FETCH;
      end
      DTX_FETCH: begin
        if (!tx_buf_empty) begin
          tx_buf_rd_dat = 1'b1;
          state_d       = DTX_LOAD;
        end
      end
      DTX_LOAD: state_d = DTX_START;
      DTX_START: begin
        dat_oe  = 1'b1;
        dat_out = 1'b0;
        crc_clr = 1'b1;
        state_d = DTX_DATA;
      end
      DTX_DATA: begin
        dat_oe  = 1'b1;
        dat_out = shreg_q[FIFO_WIDTH-1];
        crc_en  = 1'b1;
        if (refill_pt && more_words && !tx_buf_empty) tx_buf_rd_dat = 1'b1;
        if (last_bit) begin
          if (!more_words) state_d = DTX_CRC;
          else if (underrun_q) state_d = DTX_END;
        end
      end
      DTX_CRC: begin
        dat_oe  = 1'b1;
        dat_out = crc_val[crc_idx];
        if (cnt_q == CNT_W'(15)) state_d = DTX_END;
      end
      DTX_END: begin
        dat_oe  = 1'b1;
        dat_out = 1'b1;
        state_d = underrun_q ? DTX_DONE : DTX_NCRC;
      end
      DTX_NCRC: begin
        if (cnt_q == CNT_W'(1)) state_d = DTX_STAT_WAIT;
      end
      DTX_STAT_WAIT: begin
        if (!dat_in) state_d = DTX_STAT;
        else if (cnt_q == CNT_W'(STAT_TIMEOUT - 1)) state_d = DTX_DONE;
      end
      DTX_STAT: begin
        // cnt 0..2 sample the token, cnt 3 is the token's end bit
        if (cnt_q == CNT_W'(3)) state_d = STAT_NEXT;
      end
`ifdef DAT_TX_BUSY_WAIT_EN
      DTX_BUSY: begin
        if (dat_in) state_d = DTX_DONE;
      end
`endif
      DTX_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = DTX_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = DTX_IDLE;
      end
    endcase
  end

  always_ff @(posedge sd_clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt_q        <= '0;
      words_q      <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      fetch_pend_q <= 1'b0;
      underrun_q   <= 1'b0;
      tok_q        <= '0;
      err_q        <= DTX_OK;
    end else begin
      fetch_pend_q <= (state_q == DTX_DATA) && tx_buf_rd_dat;
      if (fetch_pend_q) hold_q <= tx_buf_dout;

      // One counter serves every timed state; it restarts on each state
      // change and on every word boundary inside DATA.
      if (state_q == DTX_IDLE || state_d != state_q || (state_q == DTX_DATA && last_bit)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      case (state_q)
        DTX_IDLE: begin
          if (start) begin
            words_q    <= WORDS_W'(blk_size >> 2);
            err_q      <= DTX_OK;
            underrun_q <= 1'b0;
          end
        end
        DTX_LOAD: shreg_q <= tx_buf_dout;
        DTX_DATA: begin
          if (last_bit) begin
            shreg_q <= hold_nxt;
            if (more_words) words_q <= words_q - WORDS_W'(1);
          end else begin
            shreg_q <= {shreg_q[FIFO_WIDTH-2:0], 1'b0};
          end
          // Flag now, but let the current word finish before the end bit.
          if (underrun_det) begin
            underrun_q <= 1'b1;
            err_q      <= DTX_UNDERRUN;
          end
        end
        DTX_STAT_WAIT: begin
          if (dat_in && cnt_q == CNT_W'(STAT_TIMEOUT - 1)) err_q <= DTX_TIMEOUT;
        end
        DTX_STAT: begin
          if (cnt_q < CNT_W'(3)) begin
            tok_q <= {tok_q[1:0], dat_in};
          end else if (tok_q != DTX_CRC_TOKEN) begin
            err_q <= DTX_CRC_NEG;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
